// File: rtl/acc.sv
// Per-lane signed accumulator: sums num_reads_per_iter products per lane into one output vector per iteration.
// Optional `ACC_SATURATE_EN` clamps each lane at the signed ACC_WIDTH limits instead of wrapping.
module acc #(
    parameter int NUM_INPUTS             = 8,
    parameter int DATA_WIDTH             = 8,
    parameter int ACC_WIDTH              = 32,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 configure,
    input  logic [LOG_MAX_ITERS-1:0]             num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]    num_reads_per_iter,
    input  logic [2*NUM_INPUTS*DATA_WIDTH-1:0]   data_in,
    input  logic                                 valid_in,
    output logic                                 avail_out,
    output logic [NUM_INPUTS*ACC_WIDTH-1:0]      data_out,
    output logic                                 valid_out,
    input  logic                                 avail_in
);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                                  state_q;
    logic [LOG_MAX_ITERS-1:0]                num_iters_q;
    logic [LOG_MAX_ITERS-1:0]                iter_cnt_q;
    logic [LOG_MAX_READS_PER_ITER-1:0]       num_reads_q;
    logic [LOG_MAX_READS_PER_ITER-1:0]       read_cnt_q;
    logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]    acc_q;
    logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]    sum_d;
    logic [NUM_INPUTS-1:0][ACC_WIDTH-1:0]    data_out_q;
    logic                                    valid_out_q;
    logic                                    pending_q;
    logic                                    last_read;
    logic                                    last_iter;
    logic                                    out_free;
    logic                                    rd_fire;

    function automatic logic [ACC_WIDTH-1:0] add_lane(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [PW-1:0]        p);
`ifdef ACC_SATURATE_EN
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + (ACC_WIDTH+1)'($signed(p));
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'($signed(p));
`endif
    endfunction

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            sum_d[i] = add_lane(acc_q[i], data_in[i*PW +: PW]);
    end

    assign last_read = (read_cnt_q == num_reads_q - LOG_MAX_READS_PER_ITER'(1));
    assign last_iter = (iter_cnt_q == num_iters_q - LOG_MAX_ITERS'(1));
    assign out_free  = !valid_out_q || avail_in;

    // With one read per iteration every read is a last read, so stalling on a full output
    // register would halve throughput; instead an unplaceable result parks in acc_q (pending_q)
    // and reads stop until it moves out.
    assign avail_out = (state_q == ACCUM) && !pending_q &&
                       !(last_read && valid_out_q && (num_reads_q != LOG_MAX_READS_PER_ITER'(1)));
    assign rd_fire   = valid_in && avail_out;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_iters_q <= '0;
            iter_cnt_q  <= '0;
            num_reads_q <= '0;
            read_cnt_q  <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            pending_q   <= 1'b0;
        end else if (configure) begin
            iter_cnt_q  <= '0;
            read_cnt_q  <= '0;
            acc_q       <= '0;
            valid_out_q <= 1'b0;
            pending_q   <= 1'b0;
            if (num_iters != '0 && num_reads_per_iter != '0) begin
                num_iters_q <= num_iters;
                num_reads_q <= num_reads_per_iter;
                state_q     <= ACCUM;
            end else begin
                state_q     <= IDLE;
            end
        end else begin
            if (valid_out_q && avail_in)
                valid_out_q <= 1'b0;
            if (pending_q && out_free) begin
                data_out_q  <= acc_q;
                valid_out_q <= 1'b1;
                acc_q       <= '0;
                pending_q   <= 1'b0;
            end
            if (rd_fire) begin
                if (last_read) begin
                    read_cnt_q <= '0;
                    iter_cnt_q <= iter_cnt_q + LOG_MAX_ITERS'(1);
                    if (out_free) begin
                        data_out_q  <= sum_d;
                        valid_out_q <= 1'b1;
                        acc_q       <= '0;
                    end else begin
                        acc_q     <= sum_d;
                        pending_q <= 1'b1;
                    end
                    if (last_iter)
                        state_q <= DRAIN;
                end else begin
                    acc_q      <= sum_d;
                    read_cnt_q <= read_cnt_q + LOG_MAX_READS_PER_ITER'(1);
                end
            end
            if (state_q == DRAIN && !pending_q && out_free)
                state_q <= IDLE;
        end
    end
endmodule
